// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debounce timing constants, state type and counter-width helper
// Purpose: default cycle counts at the 100 MHz system clock, the per-channel
//          press state, and the width rule used for every cycle counter.
// Ports:   none (package).
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_10MS    = 1_000_000;
  localparam int LONG_PRESS_CYCLES_500MS = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } chan_state_e;

  // Bits needed to hold 0..max_value; never narrower than one bit.
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// rtl/debounce_bank_if.sv - button bank bundle: raw inputs and debounced levels/events
// Purpose: groups the per-channel raw inputs with the clean level and event pulses.
// Ports:   button (raw, to bank), clean / rise / fall / long_press (from bank).
//          master = board/consumer side, slave = debounce_bank.
interface debounce_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] clean;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] long_press;

  modport master (output button, input clean, rise, fall, long_press);
  modport slave  (input button, output clean, rise, fall, long_press);
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, debouncer and press classifier
// Purpose: synchronise one raw level, accept a new level only after it persists,
//          and report edge and long-press events as registered one-cycle pulses.
// Ports:   clock, reset_n (async, active-low); din (raw level, polarity corrected);
//          clean (debounced level), rise / fall (edge pulses), long_press (hold pulse).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_10MS,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_500MS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_PRESS_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  chan_state_e            state_q, state_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic                   rise_d, fall_d, long_d;
  logic                   accept;

  assign s = sync_q[SYNC_STAGES-1];

  // State register: synchroniser, counters, press state and event pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      state_q    <= ST_IDLE;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      rise       <= rise_d;
      fall       <= fall_d;
      long_press <= long_d;
    end
  end

  // Next-state logic. A debounced release wins over a long-press that would
  // complete on the same edge, so the press ends with fall and no long_press.
  always_comb begin
    state_d = state_q;
    dcnt_d  = '0;
    hcnt_d  = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    long_d  = 1'b0;
    accept  = (s != clean) && (dcnt_q == DCNT_LAST);
    // Any cycle of agreement leaves dcnt_d at zero, discarding progress.
    if ((s != clean) && !accept) begin
      dcnt_d = dcnt_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PRESSED;
          rise_d  = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (accept) begin
          state_d = ST_IDLE;
          fall_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
          if (hcnt_d == HCNT_MAX) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (accept) begin
          state_d = ST_IDLE;
          fall_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the debounced level is implied by the press state.
  always_comb begin
    clean = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel button debouncer with edge and long-press events
// Purpose: applies per-channel polarity, then runs an independent debounce_channel
//          per input so simultaneous events on different channels coincide.
// Ports:   clock, reset_n (async, active-low);
//          bus (slave): button in, clean / rise / fall / long_press out.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS          = 4,
  parameter int                  SYNC_STAGES       = 2,
  parameter int                  DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_10MS,
  parameter int                  LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_500MS,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW        = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  debounce_bank_if.slave  bus
);

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] clean;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] long_press;

  // Inversion happens before synchronisation so every channel sees 1 = pressed.
  assign raw = bus.button ^ ACTIVE_LOW;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    debounce_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_channel (
      .clock     (clock),
      .reset_n   (reset_n),
      .din       (raw[i]),
      .clean     (clean[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end

  assign bus.clean      = clean;
  assign bus.rise       = rise;
  assign bus.fall       = fall;
  assign bus.long_press = long_press;

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel successor to the single-button debouncer: synchronises and debounces `CHANNELS` independent noisy inputs, then derives per-channel edge pulses and a long-press event. It sits between the board push-buttons / Morse key and the trainer's timing and decode logic, so downstream blocks receive clean levels and single-cycle events instead of re-deriving edges themselves.

## Interface
- `CHANNELS`, 4: number of independent inputs (≥1).
- `SYNC_STAGES`, 2: synchroniser flop depth per channel (≥2).
- `DEBOUNCE_CYCLES`, 1000000: consecutive mismatched cycles required to accept a new level (10 ms at 100 MHz; ≥1).
- `LONG_PRESS_CYCLES`, 50000000: cycles `clean` must stay high before `long_press` fires (0.5 s at 100 MHz; ≥1).
- `ACTIVE_LOW`, {CHANNELS{1'b0}}: per-channel mask; a set bit inverts that raw input before synchronisation.

- `clock`  in  1  100 MHz system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `button`  in  CHANNELS  raw asynchronous inputs.
- `clean`  out  CHANNELS  debounced level, 1 = pressed.
- `rise`  out  CHANNELS  one-cycle pulse when `clean` goes 0→1.
- `fall`  out  CHANNELS  one-cycle pulse when `clean` goes 1→0.
- `long_press`  out  CHANNELS  one-cycle pulse, at most once per press.

## Operation
- Per channel: `button ^ ACTIVE_LOW` → `SYNC_STAGES`-flop synchroniser → `s`.
- Debounce counter `dcnt`, width $clog2(DEBOUNCE_CYCLES+1):
  - `s == clean`: `dcnt` ← 0.
  - `s != clean` and `dcnt == DEBOUNCE_CYCLES-1`: `clean` ← `s`, `dcnt` ← 0.
  - else `dcnt` ← `dcnt`+1.
  - Any single cycle of agreement before the threshold discards progress.
- `rise`/`fall` are registered and assert in the same cycle `clean` first shows its new value; deassert the next cycle.
- Hold counter `hcnt`, width $clog2(LONG_PRESS_CYCLES+1):
  - `clean == 0`: `hcnt` ← 0.
  - `clean == 1` and `hcnt < LONG_PRESS_CYCLES`: `hcnt` ← `hcnt`+1; on the edge where `hcnt` becomes `LONG_PRESS_CYCLES`, `long_press` pulses for one cycle.
  - `hcnt` saturates at `LONG_PRESS_CYCLES`; no further pulse until `clean` returns to 0.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Per-channel state: IDLE (`clean`=0), PRESSED (`clean`=1, `hcnt` counting), LONG (`clean`=1, `hcnt` saturated). IDLE→PRESSED with `rise`; PRESSED→LONG with `long_press`; PRESSED/LONG→IDLE with `fall`.

## Timing
- Reset (`reset_n` low, asynchronous): synchroniser flops, `dcnt`, `hcnt`, `clean`, `rise`, `fall`, `long_press` all 0 immediately.
- Reset asserted mid-press: `clean` drops to 0 with no `fall` pulse. After release, a held input produces a normal `rise` once latency elapses.
- Latency, clean input step to `clean`/`rise`/`fall`: `SYNC_STAGES + DEBOUNCE_CYCLES` rising edges.
- `long_press` follows `rise` by exactly `LONG_PRESS_CYCLES` cycles.
- A release that is debounced on the same edge `hcnt` would reach the limit: `fall` fires, `long_press` does not.
- `rise` and `fall` are never both high on one channel in the same cycle.

## Structure
- Shared package `debounce_pkg`: the counter-width helper function and the default cycle constants at 100 MHz (10 ms, 0.5 s). Other timing blocks in the trainer reuse these.
- Sub-module `debounce_channel`: synchroniser, `dcnt`, `hcnt`, and edge/long logic for one bit. `debounce_bank` instantiates `CHANNELS` copies with a generate loop and applies the `ACTIVE_LOW` inversion.

## Test plan
Bench parameters: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
- Clean step on ch0 0→1, held 20 cycles → `clean[0]` and `rise[0]` high 6 edges after the step; `long_press[0]` is a single pulse 10 cycles after `rise`; then release → `fall[0]` 6 edges later.
- Ch1 toggles every 3 cycles for 30 cycles → `clean[1]` stays 0, and no pulses occur.
- Ch2 high for 3 cycles, low 1 cycle, high 4 cycles → no transition until the final 4-cycle run completes; then exactly one `rise[2]`.
- `ACTIVE_LOW`=4'b1000 with ch3 driven 1 → `clean[3]` stays 0; drive 0 → `clean[3]`=1 after 6 edges.
- Assert `reset_n` low while ch0 is in LONG → all outputs 0 asynchronously, no `fall`. Release with input still high → `rise[0]` after 6 edges.
- Step ch0 and ch2 high on the same cycle → both `rise` pulses occur in the same cycle.
